mips32_boot_loader: RTL and testbench
=====================================

# mips32_boot_loader

Byte-stream program loader for the pipelined MIPS32 core. Receives a framed program image (word count, big-endian instruction words, XOR checksum), writes each word into instruction memory starting at address 0, and holds the core halted until the whole image is written and verified. Then it pulses the core start. It is the writer side of the instruction memory that the core's fetch stage reads.

## Interface
- MEM_AW, 10, instruction memory word-address width
- MAX_WORDS, 1024, largest accepted word count (must be ≤ 2^MEM_AW)
- clk1  in  1  system clock; same clock as the core's fetch phase
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  byte offered
- in_ready  out  1  loader can accept a byte; a transfer happens when in_valid && in_ready at a rising edge of clk1
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  keeps the core halted; while high, the core has HALTED=1, PC=0, TAKEN_BRANCH=0
- cpu_start  out  1  one-cycle release pulse
- done  out  1  image loaded and verified; sticky
- err  out  1  framing or checksum failure; sticky

## Operation
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then 4·N bytes (each word MSB first), then one checksum byte.
- Checksum: XOR of every frame byte before the checksum byte, including the count bytes. The frame is good when the received checksum byte equals the running XOR.
- FSM states: S_CNT_HI → S_CNT_LO → S_DATA → S_CSUM → S_START → S_DONE. Any state can also go to S_ERR.
- S_CNT_LO: on accept, if N == 0 or N > MAX_WORDS → S_ERR. Otherwise → S_DATA.
- S_DATA: a 2-bit byte counter shifts bytes into a 32-bit assembler. On the 4th byte, the word is registered for writing and the word index increments.
  - When the index reaches N → S_CSUM.
  - Word index is MEM_AW+1 bits wide and never wraps, because N ≤ MAX_WORDS is checked first.
- S_CSUM: on accept, a match → S_START and a mismatch → S_ERR.
- Memory writes already made stay in place after an error. The core stays held, so they have no effect.
- S_START: lasts one cycle. cpu_start=1 and cpu_hold drops to 0 in the same cycle. Then → S_DONE.
- S_DONE and S_ERR are terminal until rst_n is asserted. A new load requires a reset.
- in_ready is 1 in S_CNT_HI, S_CNT_LO, S_DATA and S_CSUM, and 0 otherwise. It is combinational from state only and never depends on in_valid.
- While in_ready=0, bytes are ignored and never consumed.

## Timing
- Reset values (asynchronous):
  - state=S_CNT_HI
  - in_ready=1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1
  - cpu_start=0, done=0, err=0
  - checksum=0, word index=0, byte counter=0
- Write latency: mem_we=1 in the cycle after the 4th byte of a word is accepted.
  - In that cycle, mem_addr = word index (0-based) and mem_wdata = the assembled word.
  - mem_addr and mem_wdata hold their values until the next write.
- Back-to-back streaming gives one write every 4 cycles. Stalls (in_valid=0) may fall anywhere, including inside a word.
- If the last data word is accepted at cycle t:
  - mem_we is 1 at t+1.
  - The checksum byte can be accepted at t+1 at the earliest. The write still completes in that cycle.
  - With the checksum accepted at cycle c, cpu_start=1 at c+1, and done=1 from c+2 onward.
- err rises in the cycle after the offending byte is accepted. From then on, in_ready=0 and cpu_hold=1.
- Reset asserted mid-frame:
  - Outputs return to reset values immediately, including the mem_we deassert.
  - The partial frame is discarded; the next frame starts at CNT_HI.

## Test plan
- Frame 00 09, then nine words 2801000a 28020014 28030019 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000, checksum = XOR of all bytes → writes to addresses 0–8 with exactly those words, one cpu_start pulse, done=1. Run the core afterwards and check R4=30, R5=55.
- Same frame with in_valid toggled randomly, including gaps inside words → identical writes and addresses, no duplicate or dropped bytes.
- Same frame with the checksum byte XORed with 0x01 → all 9 writes occur, err=1, cpu_start is never 1, cpu_hold stays 1, in_ready=0.
- Count 00 00 → err=1 one cycle after CNT_LO, no mem_we. Count 04 01 with MAX_WORDS=1024 → same result.
- Reset pulse after 6 data bytes, then a fresh 1-word frame 00 01 fc 00 00 00 with checksum fd → single write of fc000000 to address 0, done=1.
- Frame of exactly MAX_WORDS words → last write at address MAX_WORDS-1, done=1.

Source files
------------

// File: rtl/mips32_boot_loader_if.sv
// Byte-stream handshake between a program-image source and the boot loader.
interface mips32_boot_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/mips32_boot_loader.sv
// Loads a framed big-endian program image into instruction memory, verifies its
// XOR checksum and releases the MIPS32 core with a single start pulse.
module mips32_boot_loader #(
  parameter int MEM_AW    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  mips32_boot_loader_if.slave     s_in,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  output logic                    cpu_hold,
  output logic                    cpu_start,
  output logic                    done,
  output logic                    err
);

  localparam logic [2:0] S_CNT_HI = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        r_state;
  logic [15:0]       r_cnt;
  logic [7:0]        r_csum;
  logic [MEM_AW:0]   r_idx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_ready;
  logic              w_xfer;
  logic [31:0]       w_cnt_new;
  logic [16:0]       w_idx_nxt;

  assign w_ready = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                   (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_xfer  = w_ready && s_in.in_valid;

  // Full count as it will be once CNT_LO is taken, widened for the range check.
  assign w_cnt_new = {16'd0, r_cnt[15:8], s_in.in_data};
  assign w_idx_nxt = {{(16 - MEM_AW){1'b0}}, r_idx} + 17'd1;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CNT_HI;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_asm       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (r_state == S_START) r_state <= S_DONE;
      if (w_xfer) begin
        case (r_state)
          S_CNT_HI: begin
            r_cnt[15:8] <= s_in.in_data;
            r_csum      <= r_csum ^ s_in.in_data;
            r_state     <= S_CNT_LO;
          end
          S_CNT_LO: begin
            r_cnt[7:0] <= s_in.in_data;
            r_csum     <= r_csum ^ s_in.in_data;
            if (w_cnt_new == 32'd0 || w_cnt_new > 32'(MAX_WORDS)) r_state <= S_ERR;
            else                                                  r_state <= S_DATA;
          end
          S_DATA: begin
            r_csum <= r_csum ^ s_in.in_data;
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= {r_asm[15:0], s_in.in_data};
            if (r_bcnt == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_idx[MEM_AW-1:0];
              r_mem_wdata <= {r_asm, s_in.in_data};
              r_idx       <= r_idx + 1'b1;
              if (w_idx_nxt == {1'b0, r_cnt}) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            r_state <= (s_in.in_data == r_csum) ? S_START : S_ERR;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign s_in.in_ready = w_ready;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  // Core is released from the start cycle onward and only on a verified image.
  assign cpu_hold      = !((r_state == S_START) || (r_state == S_DONE));
  assign cpu_start     = (r_state == S_START);
  assign done          = (r_state == S_DONE);
  assign err           = (r_state == S_ERR);

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for the MIPS32 boot loader: frame loading, stalls, errors, resets.
module tb_mips32_boot_loader;

  localparam int MEM_AW    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk1;
  logic              rst_n;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold, cpu_start, done, err;

  mips32_boot_loader_if bif ();

  mips32_boot_loader #(.MEM_AW(MEM_AW), .MAX_WORDS(MAX_WORDS)) dut (
    .clk1(clk1), .rst_n(rst_n), .s_in(bif.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .done(done), .err(err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [MEM_AW-1:0] wa[$];
  logic [31:0]       wd[$];
  int                starts;
  logic [31:0]       img[MAX_WORDS];

  always @(negedge clk1) begin
    if (rst_n && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (rst_n && cpu_start) starts++;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    starts = 0;
  endtask

  task automatic do_reset();
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    clear_log();
  endtask

  // Offers one byte from a falling edge and returns 1 time unit after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk1);
    bif.in_data  = b;
    bif.in_valid = 1'b1;
    while (!bif.in_ready && guard < 20) begin
      @(negedge clk1);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", bif.in_ready);
    end
    @(posedge clk1);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input logic [7:0] cmask, input bit stall);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'(n >> 8) ^ 8'(n);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(img[i] >> (8 * k));
        cs ^= b;
        if (stall) repeat ($urandom_range(0, 2)) @(posedge clk1);
        send_byte(b);
      end
    end
    if (stall) repeat ($urandom_range(0, 2)) @(posedge clk1);
    send_byte(cs ^ cmask);
  endtask

  task automatic load_program();
    img[0] = 32'h2801000a; img[1] = 32'h28020014; img[2] = 32'h28030019;
    img[3] = 32'h0ce77800; img[4] = 32'h0ce77800; img[5] = 32'h00222000;
    img[6] = 32'h0ce77800; img[7] = 32'h00832800; img[8] = 32'hfc000000;
  endtask

  task automatic check_program_writes(input string tag);
    n_cmp++;
    if (wa.size() !== 9) begin
      n_bad++; $display("FAIL %s_wcount: got %0d required 9", tag, wa.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (wa[i] !== 10'(i) || wd[i] !== img[i]) begin
          n_bad++;
          $display("FAIL %s_write%0d: got %0d:%h required %0d:%h", tag, i, wa[i], wd[i], i, img[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bif.in_ready, mem_we, cpu_hold, cpu_start, done, err} !== 6'b101000 ||
        mem_addr !== '0 || mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy/we/hold/start/done/err=%b addr=%h data=%h required 101000 0 0",
               {bif.in_ready, mem_we, cpu_hold, cpu_start, done, err}, mem_addr, mem_wdata);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_basic();
    logic [7:0] cs;
    do_reset();
    load_program();
    cs = 8'h00 ^ 8'h09;
    send_byte(8'h00);
    send_byte(8'h09);
    for (int i = 0; i < 9; i++)
      for (int k = 3; k >= 0; k--) begin
        cs ^= 8'(img[i] >> (8 * k));
        send_byte(8'(img[i] >> (8 * k)));
      end
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd8 || mem_wdata !== 32'hfc000000) begin
      n_bad++;
      $display("FAIL basic_last_write: we=%b addr=%0d data=%h required 1 8 fc000000", mem_we, mem_addr, mem_wdata);
    end
    send_byte(cs);
    n_cmp++;
    if (cpu_start !== 1'b1 || cpu_hold !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_start: start=%b hold=%b done=%b required 1 0 0", cpu_start, cpu_hold, done);
    end
    @(posedge clk1); #1;
    n_cmp++;
    if (done !== 1'b1 || cpu_start !== 1'b0 || bif.in_ready !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: done=%b start=%b rdy=%b err=%b required 1 0 0 0", done, cpu_start, bif.in_ready, err);
    end
    repeat (4) @(posedge clk1);
    check_program_writes("basic");
    n_cmp++;
    if (starts !== 1 || done !== 1'b1) begin
      n_bad++; $display("FAIL basic_pulse: starts=%0d done=%b required 1 1", starts, done);
    end
  endtask

  task automatic test_stalls();
    do_reset();
    load_program();
    send_image(9, 8'h00, 1'b1);
    repeat (4) @(posedge clk1);
    check_program_writes("stall");
    n_cmp++;
    if (starts !== 1 || done !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL stall_end: starts=%0d done=%b err=%b required 1 1 0", starts, done, err);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    load_program();
    send_image(9, 8'h01, 1'b0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL badcs_err_latency: err=%b required 1", err);
    end
    repeat (4) @(posedge clk1);
    check_program_writes("badcs");
    n_cmp++;
    if (starts !== 0 || cpu_hold !== 1'b1 || bif.in_ready !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL badcs_state: starts=%0d hold=%b rdy=%b done=%b required 0 1 0 0", starts, cpu_hold, bif.in_ready, done);
    end
  endtask

  task automatic test_bad_count(input logic [7:0] hi, input logic [7:0] lo);
    do_reset();
    send_byte(hi);
    send_byte(lo);
    n_cmp++;
    if (err !== 1'b1 || bif.in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL badcnt_%h%h: err=%b rdy=%b hold=%b required 1 0 1", hi, lo, err, bif.in_ready, cpu_hold);
    end
    repeat (4) @(posedge clk1);
    n_cmp++;
    if (wa.size() !== 0 || err !== 1'b1) begin
      n_bad++; $display("FAIL badcnt_%h%h_nowrite: writes=%0d err=%b required 0 1", hi, lo, wa.size(), err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h11223344) begin
      n_bad++; $display("FAIL async_pre: we=%b data=%h required 1 11223344", mem_we, mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_wdata !== 32'h0 || bif.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL async_clear: we=%b data=%h rdy=%b required 0 0 1", mem_we, mem_wdata, bif.in_ready);
    end
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hde); send_byte(8'had); send_byte(8'hbe); send_byte(8'hef);
    send_byte(8'h12); send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_wdata !== 32'h0 || mem_addr !== '0 || bif.in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_clear: data=%h addr=%0d rdy=%b hold=%b required 0 0 1 1", mem_wdata, mem_addr, bif.in_ready, cpu_hold);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    clear_log();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hfc); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hfd);
    repeat (3) @(posedge clk1);
    n_cmp++;
    if (wa.size() !== 1 || wa[0] !== '0 || wd[0] !== 32'hfc000000) begin
      n_bad++;
      $display("FAIL midrst_write: writes=%0d addr=%0d data=%h required 1 0 fc000000", wa.size(), wa[0], wd[0]);
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0 || starts !== 1) begin
      n_bad++; $display("FAIL midrst_done: done=%b err=%b starts=%0d required 1 0 1", done, err, starts);
    end
  endtask

  task automatic test_max_words();
    int bad;
    do_reset();
    for (int i = 0; i < MAX_WORDS; i++) img[i] = {i[15:0], ~i[15:0]} ^ 32'ha5000000;
    send_image(MAX_WORDS, 8'h00, 1'b0);
    repeat (3) @(posedge clk1);
    n_cmp++;
    if (wa.size() !== MAX_WORDS) begin
      n_bad++; $display("FAIL max_wcount: got %0d required %0d", wa.size(), MAX_WORDS);
    end else begin
      bad = 0;
      for (int i = 0; i < MAX_WORDS; i++)
        if (wa[i] !== 10'(i) || wd[i] !== img[i]) bad++;
      n_cmp++;
      if (bad !== 0) begin
        n_bad++; $display("FAIL max_contents: %0d wrong writes required 0", bad);
      end
      n_cmp++;
      if (wa[MAX_WORDS-1] !== 10'(MAX_WORDS - 1)) begin
        n_bad++; $display("FAIL max_last_addr: got %0d required %0d", wa[MAX_WORDS-1], MAX_WORDS - 1);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL max_done: done=%b err=%b required 1 0", done, err);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    starts       = 0;
    test_reset();
    test_basic();
    test_stalls();
    test_bad_csum();
    test_bad_count(8'h00, 8'h00);
    test_bad_count(8'h04, 8'h01);
    test_async_reset();
    test_reset_mid_frame();
    test_max_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
